// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the command master and the AHB-to-APB bridge,
// plus the master FSM state type and burst-type selection.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ADDR      = 2'b01,
        ST_DATA_LAST = 2'b10,
        ST_ERR       = 2'b11
    } mst_state_e;

    // A command that crosses a 1KB page cannot use a fixed-length burst type.
    function automatic logic [2:0] burst_for_len(input logic [3:0] len, input logic cross_1k);
        logic [2:0] burst;
        if (cross_1k) begin
            burst = HBURST_INCR;
        end else begin
            case (len)
                4'd0:    burst = HBURST_SINGLE;
                4'd3:    burst = HBURST_INCR4;
                4'd7:    burst = HBURST_INCR8;
                4'd15:   burst = HBURST_INCR16;
                default: burst = HBURST_INCR;
            endcase
        end
        return burst;
    endfunction

endpackage

// File: rtl/ahb_beat_ctr.sv
// Beat bookkeeping for ahb_master_cmd: issued/completed beat counters,
// word address incrementer and 1KB page-boundary detection.
module ahb_beat_ctr
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              issue,
    input  logic              complete,
    input  logic [7:0]        start_word,
    input  logic [3:0]        cmd_len,
    input  logic [ADDR_W-1:0] cur_addr,
    output logic [4:0]        issued_cnt,
    output logic              last_issue,
    output logic              last_cmpl,
    output logic              data_pend,
    output logic [ADDR_W-1:0] next_addr,
    output logic              next_nonseq,
    output logic              cross_1k
);

    logic [4:0] issued_cnt_r;
    logic [4:0] cmpl_cnt_r;
    logic [4:0] beats_r;
    logic [8:0] span_s;

    // Counters restart on every accepted command and advance per beat event.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt_r <= 5'd0;
            cmpl_cnt_r   <= 5'd0;
            beats_r      <= 5'd0;
        end else if (load) begin
            issued_cnt_r <= 5'd0;
            cmpl_cnt_r   <= 5'd0;
            beats_r      <= {1'b0, cmd_len} + 5'd1;
        end else begin
            issued_cnt_r <= issue    ? issued_cnt_r + 5'd1 : issued_cnt_r;
            cmpl_cnt_r   <= complete ? cmpl_cnt_r + 5'd1   : cmpl_cnt_r;
        end
    end

    // A carry out of the word index means some beat lands on the next 1KB page.
    assign span_s      = {1'b0, start_word} + {5'd0, cmd_len};
    assign cross_1k    = span_s[8];

    assign issued_cnt  = issued_cnt_r;
    assign last_issue  = (issued_cnt_r + 5'd1) == beats_r;
    assign last_cmpl   = (cmpl_cnt_r + 5'd1) == beats_r;
    assign data_pend   = issued_cnt_r != cmpl_cnt_r;
    assign next_addr   = cur_addr + ADDR_W'(3'd4);
    assign next_nonseq = next_addr[9:0] == 10'd0;

endmodule

// File: rtl/ahb_master_cmd.sv
// AHB-Lite command master: turns one start/length/direction command into a
// pipelined word burst towards the AHB-to-APB bridge, with read return and completion.
module ahb_master_cmd
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              Hready,
    input  logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Hrdata,
    output logic [ADDR_W-1:0] Haddr,
    output logic [1:0]        Htrans,
    output logic              Hwrite,
    output logic [2:0]        Hsize,
    output logic [2:0]        Hburst,
    output logic [DATA_W-1:0] Hwdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(2'b11);

    mst_state_e        state_r, state_nxt_s;
    logic [ADDR_W-1:0] haddr_r, haddr_nxt_s;
    logic [1:0]        htrans_r, htrans_nxt_s;
    logic              hwrite_r, hwrite_nxt_s;
    logic [2:0]        hburst_r, hburst_nxt_s;
    logic [DATA_W-1:0] hwdata_r, hwdata_nxt_s;
    logic [DATA_W-1:0] seed_r, seed_nxt_s;
    logic [DATA_W-1:0] rd_data_r, rd_data_nxt_s;
    logic              rd_valid_r, rd_valid_nxt_s;
    logic              done_r, done_nxt_s;
    logic              err_r, err_nxt_s;
    logic              cmd_ready_r, cmd_ready_nxt_s;

    logic              accept_s, load_s, issue_s, complete_s;
    logic [4:0]        issued_cnt_s;
    logic              last_issue_s, last_cmpl_s, data_pend_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              next_nonseq_s, cross_1k_s;

    assign accept_s = cmd_valid && cmd_ready_r;

    ahb_beat_ctr #(.ADDR_W(ADDR_W)) u_beat_ctr (
        .clk         (Hclk),
        .rst         (Hreset),
        .load        (load_s),
        .issue       (issue_s),
        .complete    (complete_s),
        .start_word  (cmd_addr[9:2]),
        .cmd_len     (cmd_len),
        .cur_addr    (haddr_r),
        .issued_cnt  (issued_cnt_s),
        .last_issue  (last_issue_s),
        .last_cmpl   (last_cmpl_s),
        .data_pend   (data_pend_s),
        .next_addr   (next_addr_s),
        .next_nonseq (next_nonseq_s),
        .cross_1k    (cross_1k_s)
    );

    // Next-state and next-output logic; every bus output holds unless Hready advances it.
    always_comb begin
        state_nxt_s    = state_r;
        haddr_nxt_s    = haddr_r;
        htrans_nxt_s   = htrans_r;
        hwrite_nxt_s   = hwrite_r;
        hburst_nxt_s   = hburst_r;
        hwdata_nxt_s   = hwdata_r;
        seed_nxt_s     = seed_r;
        rd_data_nxt_s  = rd_data_r;
        rd_valid_nxt_s = 1'b0;
        done_nxt_s     = 1'b0;
        err_nxt_s      = 1'b0;
        load_s         = 1'b0;
        issue_s        = 1'b0;
        complete_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s       = 1'b1;
                    haddr_nxt_s  = cmd_addr & WORD_MASK;
                    htrans_nxt_s = HTRANS_NONSEQ;
                    hwrite_nxt_s = cmd_write;
                    hburst_nxt_s = burst_for_len(cmd_len, cross_1k_s);
                    seed_nxt_s   = cmd_wdata;
                    state_nxt_s  = ST_ADDR;
                end else begin
                    htrans_nxt_s = HTRANS_IDLE;
                end
            end
            ST_ADDR: begin
                if (Hready) begin
                    issue_s = 1'b1;
                    if (data_pend_s && !hwrite_r) begin
                        complete_s     = 1'b1;
                        rd_data_nxt_s  = Hrdata;
                        rd_valid_nxt_s = 1'b1;
                    end else begin
                        complete_s = data_pend_s;
                    end
                    if (hwrite_r) begin
                        hwdata_nxt_s = seed_r + DATA_W'(issued_cnt_s);
                    end else begin
                        hwdata_nxt_s = hwdata_r;
                    end
                    if (last_issue_s) begin
                        htrans_nxt_s = HTRANS_IDLE;
                        state_nxt_s  = ST_DATA_LAST;
                    end else begin
                        haddr_nxt_s  = next_addr_s;
                        htrans_nxt_s = next_nonseq_s ? HTRANS_NONSEQ : HTRANS_SEQ;
                    end
                end else if (data_pend_s && (Hresp == HRESP_ERROR)) begin
                    htrans_nxt_s = HTRANS_IDLE;
                    state_nxt_s  = ST_ERR;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA_LAST: begin
                if (Hready) begin
                    complete_s = 1'b1;
                    if (!hwrite_r) begin
                        rd_data_nxt_s  = Hrdata;
                        rd_valid_nxt_s = 1'b1;
                    end else begin
                        rd_valid_nxt_s = 1'b0;
                    end
                    if (last_cmpl_s) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA_LAST;
                    end
                end else if (Hresp == HRESP_ERROR) begin
                    htrans_nxt_s = HTRANS_IDLE;
                    state_nxt_s  = ST_ERR;
                end else begin
                    state_nxt_s = ST_DATA_LAST;
                end
            end
            ST_ERR: begin
                if (Hready) begin
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                htrans_nxt_s = HTRANS_IDLE;
                state_nxt_s  = ST_IDLE;
            end
        endcase

        // Withheld during the done pulse so a coincident cmd_valid waits a cycle.
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE) && !done_nxt_s;
    end

    // State and registered outputs; reset abandons any command without a done pulse.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_r     <= ST_IDLE;
            haddr_r     <= {ADDR_W{1'b0}};
            htrans_r    <= HTRANS_IDLE;
            hwrite_r    <= 1'b0;
            hburst_r    <= HBURST_SINGLE;
            hwdata_r    <= {DATA_W{1'b0}};
            seed_r      <= {DATA_W{1'b0}};
            rd_data_r   <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            haddr_r     <= haddr_nxt_s;
            htrans_r    <= htrans_nxt_s;
            hwrite_r    <= hwrite_nxt_s;
            hburst_r    <= hburst_nxt_s;
            hwdata_r    <= hwdata_nxt_s;
            seed_r      <= seed_nxt_s;
            rd_data_r   <= rd_data_nxt_s;
            rd_valid_r  <= rd_valid_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
        end
    end

    assign Haddr     = haddr_r;
    assign Htrans    = htrans_r;
    assign Hwrite    = hwrite_r;
    assign Hsize     = HSIZE_WORD;
    assign Hburst    = hburst_r;
    assign Hwdata    = hwdata_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_ahb_master_cmd.sv
// Scoreboard bench for ahb_master_cmd: directed commands push expected address
// phases, write beats, read beats and completions; a negedge monitor pops and compares.
module tb_ahb_master_cmd;
    import ahb_pkg::*;

    logic        Hclk = 1'b0;
    logic        Hreset, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_len;
    logic        Hready;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata, Haddr, Hwdata, rd_data;
    logic [1:0]  Htrans;
    logic        Hwrite, rd_valid, done, err;
    logic [2:0]  Hsize, Hburst;

    int errors = 0;
    int checks = 0;
    int rd_total = 0;
    bit mon_en = 1'b0;
    bit mon_pend_w = 1'b0;
    bit mon_pend_r = 1'b0;

    logic [39:0] exp_addr_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] exp_rd_q[$];
    logic        exp_done_q[$];

    always #5 Hclk = ~Hclk;

    ahb_master_cmd #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .Hready(Hready), .Hresp(Hresp), .Hrdata(Hrdata), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Hwdata(Hwdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err)
    );

    function automatic logic [39:0] ap(input logic [31:0] a, input logic [1:0] t,
                                       input logic [2:0] b, input logic w);
        return {2'b00, a, t, b, w};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: DUT produced %h with nothing expected", name, act);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_htrans"},    64'(Htrans),    64'(HTRANS_IDLE));
        chk({tag, "_haddr"},     64'(Haddr),     64'd0);
        chk({tag, "_hwrite"},    64'(Hwrite),    64'd0);
        chk({tag, "_hburst"},    64'(Hburst),    64'(HBURST_SINGLE));
        chk({tag, "_hwdata"},    64'(Hwdata),    64'd0);
        chk({tag, "_hsize"},     64'(Hsize),     64'(HSIZE_WORD));
        chk({tag, "_rd_data"},   64'(rd_data),   64'd0);
        chk({tag, "_rd_valid"},  64'(rd_valid),  64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_err"},       64'(err),       64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an observable event.
    initial begin : monitor
        forever begin
            @(negedge Hclk);
            if (mon_en) begin
                if (mon_pend_w && Hready && (Hresp == HRESP_OKAY)) begin
                    if (exp_wd_q.size() == 0) unexp("wdata", 64'(Hwdata));
                    else chk("wdata", 64'(Hwdata), 64'(exp_wd_q.pop_front()));
                end
                if (mon_pend_r && Hready && (Hresp == HRESP_OKAY)) rd_total++;
                if (Hready && (Htrans != HTRANS_IDLE)) begin
                    if (exp_addr_q.size() == 0) unexp("addr_phase", 64'(Haddr));
                    else chk("addr_phase", 64'(ap(Haddr, Htrans, Hburst, Hwrite)),
                             64'(exp_addr_q.pop_front()));
                end
                if (rd_valid) begin
                    if (exp_rd_q.size() == 0) unexp("rd_data", 64'(rd_data));
                    else chk("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
                end
                if (done) begin
                    if (exp_done_q.size() == 0) unexp("done", 64'(err));
                    else chk("done_err", 64'(err), 64'(exp_done_q.pop_front()));
                end
                if (Hreset) begin
                    mon_pend_w = 1'b0;
                    mon_pend_r = 1'b0;
                end else if (Hready) begin
                    mon_pend_w = (Htrans != HTRANS_IDLE) && Hwrite;
                    mon_pend_r = (Htrans != HTRANS_IDLE) && !Hwrite;
                end
            end
        end
    end

    // Issues one command at cycle 0 and scripts the slave per cycle c after acceptance.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] seed, input logic [31:0] rbase,
                           input logic [63:0] stall_m, input logic [63:0] err_m,
                           input int exp_done_c, input string name);
        int k0;
        bit seen;
        k0 = rd_total;
        seen = 1'b0;
        chk({name, "_cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = seed;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge Hclk); #1;
            cmd_valid = 1'b0;
            Hready = !stall_m[c];
            Hresp  = err_m[c] ? HRESP_ERROR : HRESP_OKAY;
            Hrdata = rbase * 32'(rd_total - k0 + 1);
            @(negedge Hclk);
            if (name == "wait" && c >= 3 && c <= 5) begin
                chk("wait_haddr_hold", 64'(Haddr), 64'h8000_0108);
                chk("wait_hwdata_hold", 64'(Hwdata), 64'h1000_0001);
            end
            if (name == "error" && c == 5) chk("error_htrans_idle", 64'(Htrans), 64'(HTRANS_IDLE));
            if (done) begin
                seen = 1'b1;
                chk({name, "_done_cycle"}, 64'(c), 64'(exp_done_c));
                chk({name, "_cmd_ready_in_done"}, 64'(cmd_ready), 64'd0);
            end
        end
        if (!seen) chk({name, "_done_timeout"}, 64'(seen), 64'd1);
        @(posedge Hclk); #1;
        Hready = 1'b1; Hresp = HRESP_OKAY;
        chk({name, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        Hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 4'd0;
        cmd_wdata = 32'd0; Hready = 1'b1; Hresp = HRESP_OKAY; Hrdata = 32'd0;
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        chk_reset("init");
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        mon_en = 1'b1;

        // Single write
        exp_addr_q.push_back(ap(32'h8000_0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1));
        exp_wd_q.push_back(32'hA5A5_0000);
        exp_done_q.push_back(1'b0);
        run_cmd(1'b1, 32'h8000_0000, 4'd0, 32'hA5A5_0000, 32'd0, 64'd0, 64'd0, 3, "single");

        // INCR4 read
        exp_addr_q.push_back(ap(32'h8000_0010, HTRANS_NONSEQ, HBURST_INCR4, 1'b0));
        exp_addr_q.push_back(ap(32'h8000_0014, HTRANS_SEQ,    HBURST_INCR4, 1'b0));
        exp_addr_q.push_back(ap(32'h8000_0018, HTRANS_SEQ,    HBURST_INCR4, 1'b0));
        exp_addr_q.push_back(ap(32'h8000_001C, HTRANS_SEQ,    HBURST_INCR4, 1'b0));
        exp_rd_q.push_back(32'h11); exp_rd_q.push_back(32'h22);
        exp_rd_q.push_back(32'h33); exp_rd_q.push_back(32'h44);
        exp_done_q.push_back(1'b0);
        run_cmd(1'b0, 32'h8000_0010, 4'd3, 32'd0, 32'h11, 64'd0, 64'd0, 6, "incr4_rd");

        // INCR4 write with two wait states on the second data phase
        exp_addr_q.push_back(ap(32'h8000_0100, HTRANS_NONSEQ, HBURST_INCR4, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_0104, HTRANS_SEQ,    HBURST_INCR4, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_0108, HTRANS_SEQ,    HBURST_INCR4, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_010C, HTRANS_SEQ,    HBURST_INCR4, 1'b1));
        exp_wd_q.push_back(32'h1000_0000); exp_wd_q.push_back(32'h1000_0001);
        exp_wd_q.push_back(32'h1000_0002); exp_wd_q.push_back(32'h1000_0003);
        exp_done_q.push_back(1'b0);
        run_cmd(1'b1, 32'h8000_0100, 4'd3, 32'h1000_0000, 32'd0, 64'h18, 64'd0, 8, "wait");

        // 1KB crossing, write seed wraps modulo 2^32
        exp_addr_q.push_back(ap(32'h8000_03F8, HTRANS_NONSEQ, HBURST_INCR, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_03FC, HTRANS_SEQ,    HBURST_INCR, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_0400, HTRANS_NONSEQ, HBURST_INCR, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_0404, HTRANS_SEQ,    HBURST_INCR, 1'b1));
        exp_wd_q.push_back(32'hFFFF_FFFE); exp_wd_q.push_back(32'hFFFF_FFFF);
        exp_wd_q.push_back(32'h0000_0000); exp_wd_q.push_back(32'h0000_0001);
        exp_done_q.push_back(1'b0);
        run_cmd(1'b1, 32'h8000_03F8, 4'd3, 32'hFFFF_FFFE, 32'd0, 64'd0, 64'd0, 6, "cross1k");

        // INCR8 read, ERROR on beat 3 (Hready 0 then 1)
        exp_addr_q.push_back(ap(32'h8000_0200, HTRANS_NONSEQ, HBURST_INCR8, 1'b0));
        exp_addr_q.push_back(ap(32'h8000_0204, HTRANS_SEQ,    HBURST_INCR8, 1'b0));
        exp_addr_q.push_back(ap(32'h8000_0208, HTRANS_SEQ,    HBURST_INCR8, 1'b0));
        exp_rd_q.push_back(32'h0101_0101); exp_rd_q.push_back(32'h0202_0202);
        exp_done_q.push_back(1'b1);
        run_cmd(1'b0, 32'h8000_0200, 4'd7, 32'd0, 32'h0101_0101, 64'h10, 64'h30, 6, "error");

        // Reset during beat 2 of an INCR4 write
        exp_addr_q.push_back(ap(32'h8000_0040, HTRANS_NONSEQ, HBURST_INCR4, 1'b1));
        exp_addr_q.push_back(ap(32'h8000_0044, HTRANS_SEQ,    HBURST_INCR4, 1'b1));
        exp_wd_q.push_back(32'h5555_0000);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0040; cmd_len = 4'd3;
        cmd_wdata = 32'h5555_0000;
        @(posedge Hclk); #1; cmd_valid = 1'b0;
        @(posedge Hclk); #1; Hreset = 1'b1;
        @(posedge Hclk); #1; Hreset = 1'b0;
        @(negedge Hclk);
        chk_reset("midrst");
        for (int i = 0; i < 4; i++) begin
            @(posedge Hclk); #1;
            @(negedge Hclk);
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        @(posedge Hclk); #1;

        // Unaligned start address is forced to a word boundary
        exp_addr_q.push_back(ap(32'h0000_0004, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0));
        exp_rd_q.push_back(32'hDEAD_BEEF);
        exp_done_q.push_back(1'b0);
        run_cmd(1'b0, 32'h0000_0007, 4'd0, 32'd0, 32'hDEAD_BEEF, 64'd0, 64'd0, 3, "unaligned");

        // INCR16 read
        for (int i = 0; i < 16; i++) begin
            exp_addr_q.push_back(ap(32'h8000_0800 + 32'(4 * i),
                                    (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR16, 1'b0));
            exp_rd_q.push_back(32'h10 * 32'(i + 1));
        end
        exp_done_q.push_back(1'b0);
        run_cmd(1'b0, 32'h8000_0800, 4'd15, 32'd0, 32'h10, 64'd0, 64'd0, 18, "incr16");

        repeat (2) @(posedge Hclk);
        chk("addr_q_left", 64'(exp_addr_q.size()), 64'd0);
        chk("wdata_q_left", 64'(exp_wd_q.size()), 64'd0);
        chk("rd_q_left", 64'(exp_rd_q.size()), 64'd0);
        chk("done_q_left", 64'(exp_done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
